restador_serial_4bits: RTL and testbench

- Bit-serial 4-bit subtractor: the inverse operation to the team's parallel 4-bit ripple adder.
- Uses a single full-subtractor cell and processes one bit per clock, LSB first, with a registered borrow chain.
- Result has the same 5-bit format as the adder: 4-bit difference plus a borrow-out in the MSB.
- Used as the subtract path of the datapath's ALU exercises, driven by a start/done handshake.

---
 rtl/restador_serial_4bits.sv | 98 +++++++++
 tb/tb_restador_serial_4bits.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/restador_serial_4bits.sv
// Bit-serial N-bit subtractor: one full-subtractor cell, LSB first, registered borrow.
// W = {borrow_out, X - Y - bin}, with a start/busy/done handshake.
module restador_serial_4bits #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N:0]   W
);

    // state | meaning
    // IDLE  | waiting for start, W holds the last result
    // SHIFT | one bit of the difference produced per clock
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_next;
    logic [N-1:0]   x_sh, y_sh, diff;
    logic           br;
    logic [CW-1:0]  cnt;
    logic           load, last;
    logic           a, b, d, br_next;

    assign a       = x_sh[0];
    assign b       = y_sh[0];
    assign d       = a ^ b ^ br;
    assign br_next = (~a & b) | (~a & br) | (b & br);
    assign busy    = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(N - 1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured only on an accepted start, so inputs may move while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_sh <= '0;
            y_sh <= '0;
            diff <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            W    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                x_sh <= X;
                y_sh <= Y;
                br   <= bin;
                diff <= '0;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                diff <= {d, diff[N-1:1]};
                x_sh <= x_sh >> 1;
                y_sh <= y_sh >> 1;
                br   <= br_next;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    W    <= {br_next, d, diff[N-1:1]};
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_restador_serial_4bits.sv
// Self-checking bench for restador_serial_4bits: arithmetic reference model checked every cycle,
// plus directed cases with hand-computed results and latency.
module tb_restador_serial_4bits;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] X = '0;
    logic [N-1:0] Y = '0;
    logic         bin = 1'b0;
    logic         busy, done;
    logic [N:0]   W;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    restador_serial_4bits #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .bin(bin),
        .busy(busy), .done(done), .W(W)
    );

    always #5 clk = ~clk;

    // Reference: a countdown of remaining cycles and the arithmetically computed result.
    int         rem = 0;
    logic [N:0] pend = '0;
    logic [N:0] exp_w = '0;
    logic       exp_done = 1'b0;

    function automatic logic [N:0] sub_ref(input logic [N-1:0] x, input logic [N-1:0] y, input logic b);
        int diff;
        logic [N:0] r;
        diff      = int'(x) - int'(y) - int'(b);
        r[N-1:0]  = diff[N-1:0];
        r[N]      = (int'(x) < int'(y) + int'(b));
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            rem      = 0;
            exp_w    = '0;
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (rem > 0) begin
                rem = rem - 1;
                if (rem == 0) begin
                    exp_w    = pend;
                    exp_done = 1'b1;
                end
            end else if (start) begin
                rem  = N;
                pend = sub_ref(X, Y, bin);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (busy !== (rem > 0)) begin
                errors++;
                $display("FAIL busy t=%0t got %b exp %b", $time, busy, (rem > 0));
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done t=%0t got %b exp %b", $time, done, exp_done);
            end
            checks++;
            if (W !== exp_w) begin
                errors++;
                $display("FAIL w t=%0t got %b exp %b", $time, W, exp_w);
            end
        end
    end

    task automatic check_val(input string name, input logic [N:0] got, input logic [N:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", name, got, exp);
        end
    endtask

    // Called at a negedge; drives a one-cycle start and returns at the following negedge.
    task automatic op(input logic [N-1:0] x, input logic [N-1:0] y, input logic b);
        X = x; Y = y; bin = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        X = N'($urandom); Y = N'($urandom); bin = 1'($urandom);
    endtask

    // Waits for done with a bound, scrambling inputs meanwhile; returns cycles waited.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!done) begin
                X = N'($urandom); Y = N'($urandom); bin = 1'($urandom);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got 0 exp 1");
        end
    endtask

    task automatic directed(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                            input logic b, input logic [N:0] lit);
        int cyc;
        op(x, y, b);
        wait_done(cyc);
        check_val(name, W, lit);
        check_val({name, "_model"}, exp_w, lit);
        check_val({name, "_lat"}, 5'(cyc), 5'(N));
    endtask

    initial begin
        int cyc;
        bit saw_done;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        check_val("reset_w", W, 5'b00000);
        check_val("reset_busy", {4'b0, busy}, 5'b0);
        check_val("reset_done", {4'b0, done}, 5'b0);

        directed("x9_y3",   4'd9,  4'd3,  1'b0, 5'b00110);
        directed("x3_y9",   4'd3,  4'd9,  1'b0, 5'b11010);
        directed("x0_y0_b", 4'd0,  4'd0,  1'b1, 5'b11111);
        directed("x15_y15", 4'd15, 4'd15, 1'b0, 5'b00000);

        // start while busy is ignored
        op(4'd12, 4'd5, 1'b0);
        @(negedge clk);
        X = 4'd1; Y = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check_val("busy_start_ignored", W, 5'b00111);

        // mid-operation reset aborts with no done
        @(negedge clk);
        op(4'd12, 4'd5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_w", W, 5'b00000);
        check_val("abort_busy", {4'b0, busy}, 5'b0);
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_val("abort_no_done", {4'b0, saw_done}, 5'b0);
        directed("x7_y7", 4'd7, 4'd7, 1'b0, 5'b00000);

        // start in the done cycle: back-to-back
        directed("b2b_first", 4'd9, 4'd3, 1'b0, 5'b00110);
        directed("b2b_second", 4'd8, 4'd1, 1'b0, 5'b00111);

        // exhaustive sweep, issued back-to-back
        for (int i = 0; i < 512; i++) begin
            op(N'(i[3:0]), N'(i[7:4]), i[8]);
            wait_done(cyc);
            check_val("sweep_lat", 5'(cyc), 5'(N));
        end

        // random traffic with occasional resets
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 2) == 0);
            X     = N'($urandom);
            Y     = N'($urandom);
            bin   = 1'($urandom);
            rst   = ($urandom_range(0, 60) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
